// File: rtl/cronometro_pkg.sv
// Shared definitions for the stopwatch controller: state encoding and BCD digit limits.
package cronometro_pkg;

  localparam int DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    PAUSED  = 2'b10
  } state_t;

  localparam logic [DIGIT_W-1:0] LIM_SEC_U = 4'd9;
  localparam logic [DIGIT_W-1:0] LIM_SEC_D = 4'd5;
  localparam logic [DIGIT_W-1:0] LIM_MIN_U = 4'd9;
  localparam logic [DIGIT_W-1:0] LIM_MIN_D = 4'd9;

endpackage

// File: rtl/contador_bcd.sv
// Single BCD digit counter with programmable limit; carry is raised when the digit
// rolls over from its limit back to zero.
module contador_bcd
  import cronometro_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               clr,
  input  logic [DIGIT_W-1:0] limit,
  output logic [DIGIT_W-1:0] digit,
  output logic               carry
);

  logic at_limit;

  assign at_limit = (digit == limit);
  assign carry    = inc && at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      digit <= '0;
    else if (clr)
      digit <= '0;
    else if (inc)
      digit <= at_limit ? '0 : digit + 1'b1;
  end

endmodule

// File: rtl/cronometro_ctrl.sv
// Stopwatch controller: IDLE/RUNNING/PAUSED FSM, BCD mm:ss accumulator, display drive.
// Optional lap-freeze display is enabled by defining CRONOMETRO_LAP_EN.
module cronometro_ctrl
  import cronometro_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               btn_start_stop,
  input  logic               btn_clear,
  input  logic               btn_lap,
  output logic               div_rst_n,
  output logic               run,
  output logic [DIGIT_W-1:0] min_d,
  output logic [DIGIT_W-1:0] min_u,
  output logic [DIGIT_W-1:0] sec_d,
  output logic [DIGIT_W-1:0] sec_u,
  output logic               overflow,
  output logic               lap_active
);

  state_t state, next_state;

  logic               count_en;
  logic               clear_cnt;
  logic [3:0]         carry;
  logic [DIGIT_W-1:0] live_min_d, live_min_u, live_sec_d, live_sec_u;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      run       <= 1'b0;
      div_rst_n <= 1'b0;
    end else begin
      state     <= next_state;
      run       <= (next_state == RUNNING);
      div_rst_n <= (next_state != IDLE);
    end
  end

  // Clear has priority over start/stop when both arrive while paused.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (btn_start_stop) next_state = RUNNING;
      RUNNING: if (btn_start_stop) next_state = PAUSED;
      PAUSED: begin
        if (btn_clear)           next_state = IDLE;
        else if (btn_start_stop) next_state = RUNNING;
      end
      default: next_state = IDLE;
    endcase
  end

  // Ticks count on the current state, so a stop pulse still lets its tick through.
  assign count_en  = tick && (state == RUNNING);
  assign clear_cnt = btn_clear && (state == PAUSED);

  contador_bcd u_sec_u (.clk(clk), .rst(rst), .inc(count_en), .clr(clear_cnt),
                        .limit(LIM_SEC_U), .digit(live_sec_u), .carry(carry[0]));
  contador_bcd u_sec_d (.clk(clk), .rst(rst), .inc(carry[0]), .clr(clear_cnt),
                        .limit(LIM_SEC_D), .digit(live_sec_d), .carry(carry[1]));
  contador_bcd u_min_u (.clk(clk), .rst(rst), .inc(carry[1]), .clr(clear_cnt),
                        .limit(LIM_MIN_U), .digit(live_min_u), .carry(carry[2]));
  contador_bcd u_min_d (.clk(clk), .rst(rst), .inc(carry[2]), .clr(clear_cnt),
                        .limit(LIM_MIN_D), .digit(live_min_d), .carry(carry[3]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (clear_cnt)
      overflow <= 1'b0;
    else if (carry[3])
      overflow <= 1'b1;
  end

`ifdef CRONOMETRO_LAP_EN
  logic                   lap_q;
  logic [4*DIGIT_W-1:0]   snap;

  // A lap press toggles the freeze; freezing is only allowed while running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lap_q <= 1'b0;
      snap  <= '0;
    end else if (clear_cnt) begin
      lap_q <= 1'b0;
    end else if (btn_lap) begin
      if (lap_q && (state != IDLE)) begin
        lap_q <= 1'b0;
      end else if (!lap_q && (state == RUNNING)) begin
        lap_q <= 1'b1;
        snap  <= {live_min_d, live_min_u, live_sec_d, live_sec_u};
      end
    end
  end

  assign lap_active = lap_q;
  assign {min_d, min_u, sec_d, sec_u} = lap_q ? snap
                                              : {live_min_d, live_min_u, live_sec_d, live_sec_u};
`else
  logic unused_lap;

  assign unused_lap = btn_lap;
  assign lap_active = 1'b0;
  assign {min_d, min_u, sec_d, sec_u} = {live_min_d, live_min_u, live_sec_d, live_sec_u};
`endif

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Directed self-checking bench for cronometro_ctrl; lap checks follow CRONOMETRO_LAP_EN.
module tb_cronometro_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       btn_start_stop = 1'b0;
  logic       btn_clear = 1'b0;
  logic       btn_lap = 1'b0;
  logic       div_rst_n, run, overflow, lap_active;
  logic [3:0] min_d, min_u, sec_d, sec_u;

  int tests = 0;
  int fails = 0;

  cronometro_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick),
    .btn_start_stop(btn_start_stop), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .div_rst_n(div_rst_n), .run(run),
    .min_d(min_d), .min_u(min_u), .sec_d(sec_d), .sec_u(sec_u),
    .overflow(overflow), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then land 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic ss, input logic clr, input logic lap, input logic tk);
    btn_start_stop = ss;
    btn_clear      = clr;
    btn_lap        = lap;
    tick           = tk;
    @(posedge clk);
    #1;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    btn_lap        = 1'b0;
    tick           = 1'b0;
  endtask

  task automatic sendTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Observed vector: {run, div_rst_n, overflow, lap_active, mm:ss in BCD}
  task automatic checkOutput(input string tag, input logic e_run, input logic e_div,
                             input logic e_ov, input logic e_lap, input logic [15:0] e_time);
    logic [19:0] obs, exp_v;
    obs   = {run, div_rst_n, overflow, lap_active, min_d, min_u, sec_d, sec_u};
    exp_v = {e_run, e_div, e_ov, e_lap, e_time};
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("[TB] FAIL %s: observed run/div/ov/lap=%b%b%b%b time=%h, expected %b%b%b%b time=%h",
             tag, obs[19], obs[18], obs[17], obs[16], obs[15:0],
             exp_v[19], exp_v[18], exp_v[17], exp_v[16], exp_v[15:0]);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_values", 0, 0, 0, 0, 16'h0000);
    rst = 1'b0;

    applyStimulus(0, 0, 0, 1);
    checkOutput("idle_tick_ignored", 0, 0, 0, 0, 16'h0000);
    applyStimulus(0, 1, 0, 0);
    checkOutput("idle_clear_ignored", 0, 0, 0, 0, 16'h0000);

    applyStimulus(1, 0, 0, 0);
    checkOutput("start", 1, 1, 0, 0, 16'h0000);
    applyStimulus(0, 0, 0, 1);
    checkOutput("first_tick", 1, 1, 0, 0, 16'h0001);
    sendTicks(60);
    checkOutput("61_ticks", 1, 1, 0, 0, 16'h0101);
    applyStimulus(1, 0, 0, 0);
    checkOutput("stop", 0, 1, 0, 0, 16'h0101);
    sendTicks(5);
    checkOutput("paused_ticks_dropped", 0, 1, 0, 0, 16'h0101);
    applyStimulus(1, 0, 0, 1);
    checkOutput("start_tick_not_counted", 1, 1, 0, 0, 16'h0101);
    applyStimulus(1, 0, 0, 1);
    checkOutput("stop_tick_counted", 0, 1, 0, 0, 16'h0102);
    applyStimulus(0, 1, 0, 0);
    checkOutput("clear_paused", 0, 0, 0, 0, 16'h0000);

    applyStimulus(1, 0, 0, 0);
    sendTicks(5);
    applyStimulus(0, 1, 0, 0);
    checkOutput("clear_running_ignored", 1, 1, 0, 0, 16'h0005);
    applyStimulus(0, 0, 0, 1);
    checkOutput("count_continues", 1, 1, 0, 0, 16'h0006);
    applyStimulus(1, 0, 0, 0);
    checkOutput("stop_again", 0, 1, 0, 0, 16'h0006);
    applyStimulus(1, 1, 0, 0);
    checkOutput("clear_beats_start", 0, 0, 0, 0, 16'h0000);

    applyStimulus(1, 0, 0, 0);
    sendTicks(5999);
    checkOutput("at_99_59", 1, 1, 0, 0, 16'h9959);
    applyStimulus(0, 0, 0, 1);
    checkOutput("wrap_overflow", 1, 1, 1, 0, 16'h0000);
    applyStimulus(0, 0, 0, 1);
    checkOutput("overflow_sticky", 1, 1, 1, 0, 16'h0001);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("clear_overflow", 0, 0, 0, 0, 16'h0000);

`ifdef CRONOMETRO_LAP_EN
    applyStimulus(1, 0, 0, 0);
    sendTicks(10);
    applyStimulus(0, 0, 1, 0);
    checkOutput("lap_set", 1, 1, 0, 1, 16'h0010);
    sendTicks(5);
    checkOutput("lap_frozen", 1, 1, 0, 1, 16'h0010);
    applyStimulus(0, 0, 1, 0);
    checkOutput("lap_release", 1, 1, 0, 0, 16'h0015);
    applyStimulus(0, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("paused_frozen", 0, 1, 0, 1, 16'h0015);
    applyStimulus(0, 0, 1, 0);
    checkOutput("paused_release", 0, 1, 0, 0, 16'h0015);
    applyStimulus(0, 0, 1, 0);
    checkOutput("paused_lap_ignored", 0, 1, 0, 0, 16'h0015);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("lap_idle_ignored", 0, 0, 0, 0, 16'h0000);
`else
    applyStimulus(1, 0, 0, 0);
    sendTicks(10);
    applyStimulus(0, 0, 1, 0);
    checkOutput("lap_disabled", 1, 1, 0, 0, 16'h0010);
    for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 1);
    checkOutput("lap_disabled_tracks", 1, 1, 0, 0, 16'h0015);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0);
    applyStimulus(0, 0, 1, 0);
    checkOutput("lap_disabled_idle", 0, 0, 0, 0, 16'h0000);
`endif

    applyStimulus(1, 0, 0, 0);
    sendTicks(3);
    checkOutput("before_async_reset", 1, 1, 0, 0, 16'h0003);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset", 0, 0, 0, 0, 16'h0000);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1);
    checkOutput("after_reset_idle", 0, 0, 0, 0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cronometro_ctrl.md
# cronometro_ctrl

Stopwatch controller sitting between the button front-end, the 1 Hz divider and the display driver. Runs an IDLE/RUNNING/PAUSED state machine from single-cycle button pulses and holds the divider in reset while idle. Accumulates divider ticks into a BCD mm:ss count from 00:00 to 99:59. Drives the four display digits, with an optional lap-freeze feature.

## Interface
- No parameters. Digit limits are fixed constants in the shared package.
- `clk`  in  1  system clock, 50 MHz board clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle pulse per second from the divider.
- `btn_start_stop`  in  1  one-cycle pulse, already debounced and edge-detected.
- `btn_clear`  in  1  one-cycle pulse.
- `btn_lap`  in  1  one-cycle pulse. Ignored unless `CRONOMETRO_LAP_EN` is defined.
- `div_rst_n`  out  1  active-low reset to the divider.
- `run`  out  1  high while in RUNNING.
- `min_d`, `min_u`, `sec_d`, `sec_u`  out  4 each  displayed BCD digits.
- `overflow`  out  1  sticky; set on wrap from 99:59 to 00:00.
- `lap_active`  out  1  high while the display is frozen.

## Operation
- States: IDLE, RUNNING, PAUSED.
- IDLE:
  - `btn_start_stop` → RUNNING.
  - `btn_clear` and `btn_lap` are ignored.
- RUNNING:
  - `btn_start_stop` → PAUSED.
  - `btn_clear` is ignored.
  - `tick` increments the count.
- PAUSED:
  - `btn_start_stop` → RUNNING.
  - `btn_clear` → IDLE. Zeroes the count, `overflow` and `lap_active`.
- Simultaneous `btn_clear` and `btn_start_stop` in PAUSED: clear wins and the next state is IDLE.
- `tick` is counted only when the current state is RUNNING:
  - A tick in the same cycle as stop in RUNNING is counted.
  - A tick in the same cycle as start in PAUSED is not counted.
- Count arithmetic, digit by digit:
  - `sec_u` counts 0–9; its carry feeds `sec_d`.
  - `sec_d` counts 0–5; its carry feeds `min_u`.
  - `min_u` counts 0–9; its carry feeds `min_d`.
  - `min_d` counts 0–9.
  - At 99:59 a tick wraps the count to 00:00 and sets `overflow`. The count keeps running.
- `div_rst_n` is 0 in IDLE and 1 in RUNNING and PAUSED. In PAUSED the divider keeps running and its ticks are discarded.
- `run` equals (state == RUNNING).

## Timing
- Every output is registered.
- Reset values:
  - state IDLE
  - all digits 0
  - `overflow` 0
  - `run` 0
  - `div_rst_n` 0
  - `lap_active` 0
- Button pulse in cycle N: new state, `run` and `div_rst_n` are visible in cycle N+1.
- `tick` in cycle N: updated digits and `overflow` are visible in cycle N+1.
- Asserting `rst` mid-count forces the reset values immediately. There is no partial-state retention.
- Buttons are pulses. Holding a button high for k cycles acts as k presses. Debouncing is the upstream block's job.

## Configuration
- `CRONOMETRO_LAP_EN` defined:
  - `btn_lap` in RUNNING with `lap_active`=0 captures the live count into a snapshot register and sets `lap_active`. The displayed digits then show the snapshot.
  - `btn_lap` with `lap_active`=1, in RUNNING or PAUSED, clears `lap_active`. The display shows the live count from the next cycle.
  - `btn_lap` is ignored in IDLE and in PAUSED with `lap_active`=0.
  - The internal count and `overflow` are unaffected by lap.
  - Clear also clears `lap_active`.
- `CRONOMETRO_LAP_EN` not defined:
  - `btn_lap` is unused.
  - `lap_active` is tied to 0.
  - The digits always show the live count.
  - No snapshot registers are built.

## Structure
- Shared package `cronometro_pkg` holds:
  - state encoding: IDLE=2'b00, RUNNING=2'b01, PAUSED=2'b10
  - digit limits: 9, 5, 9, 9
  - BCD digit width: 4
- One sub-module, `contador_bcd`, instantiated four times:
  - inputs: increment enable, synchronous clear, limit value
  - outputs: 4-bit digit, and a carry when the digit is at its limit and incrementing

## Test plan
- Reset then start: `div_rst_n` and `run` go from 0 to 1 one cycle after the pulse. Digits stay 00:00 until the first `tick`, then read 00:01.
- 61 ticks in RUNNING → display 01:01. Stop, send 5 ticks, then start → still 01:01. A tick coincident with the stop pulse is counted (62 ticks → 01:02).
- Preload to 99:59 and send 1 tick → 00:00 with `overflow`=1. A further tick → 00:01 with `overflow` still 1. Stop then clear → IDLE, 00:00, `overflow`=0, `div_rst_n`=0.
- Clear in RUNNING → ignored, counting continues. Clear and start_stop in the same cycle in PAUSED → IDLE with 00:00.
- With LAP_EN: lap at 00:10, then 5 ticks → display 00:10, `lap_active`=1. Second lap → display 00:15. Lap in IDLE → no effect.
- Without LAP_EN: lap pulses at any time → `lap_active`=0 and the display tracks the live count.
